// File: rtl/nes_pkg.sv
// Shared constants and types for the NES controller port block.
package nes_pkg;

    localparam logic [15:0] JOY1_ADDR    = 16'h4016;
    localparam logic [15:0] JOY2_ADDR    = 16'h4017;
    localparam logic [7:0]  JOY_OPEN_BUS = 8'h40;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [7:0] pad_t;

    // Serial readout: LSB leaves first, the vacated MSB fills with 1 like the real 4021.
    function automatic pad_t shift_in_one(input pad_t s);
        return {1'b1, s[7:1]};
    endfunction

endpackage

// File: rtl/nes_btn_debounce.sv
// One 8-button pad: 2-FF synchroniser plus an independent debounce counter per bit.
module nes_btn_debounce
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic sys_clock,
    input  logic reset,
    input  pad_t raw,
    output pad_t state
);

    pad_t sync1, sync2;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 8; b++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             deb;

        // Counter only runs while the synchronised input disagrees with the
        // debounced value; any return to agreement restarts the hold window.
        always_ff @(posedge sys_clock or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (sync2[b] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2[b];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign state[b] = deb;
    end

endmodule

// File: rtl/nes_joypad_if.sv
// Controller port block: debounced pads, $4016 strobe latch and $4016/$4017 serial readout.
module nes_joypad_if
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic [7:0]  pad1_raw,
    input  logic [7:0]  pad2_raw,
    output logic [7:0]  pad1_state,
    output logic [7:0]  pad2_state
);

    logic strobe, strobe_next, load, wr_joy;
    logic rd1, rd2;
    pad_t shift1, shift2;

    nes_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pad1 (
        .sys_clock (sys_clock),
        .reset     (reset),
        .raw       (pad1_raw),
        .state     (pad1_state)
    );

    nes_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pad2 (
        .sys_clock (sys_clock),
        .reset     (reset),
        .raw       (pad2_raw),
        .state     (pad2_state)
    );

    assign wr_joy      = cpu_ce && cpu_wr && (cpu_addr == JOY1_ADDR);
    assign rd1         = cpu_ce && cpu_rd && (cpu_addr == JOY1_ADDR);
    assign rd2         = cpu_ce && cpu_rd && (cpu_addr == JOY2_ADDR);
    assign strobe_next = wr_joy ? cpu_wdata[0] : strobe;
    // Old strobe covers the 1->0 final load; new strobe covers a 0->1 write,
    // which also suppresses the shift of a read in the same cycle.
    assign load        = strobe || strobe_next;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            strobe     <= 1'b0;
            shift1     <= '0;
            shift2     <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            strobe     <= strobe_next;
            cpu_rvalid <= rd1 || rd2;
            if (rd1)
                cpu_rdata <= JOY_OPEN_BUS | {7'd0, shift1[BTN_A]};
            else if (rd2)
                cpu_rdata <= JOY_OPEN_BUS | {7'd0, shift2[BTN_A]};

            if (load) begin
                shift1 <= pad1_state;
                shift2 <= pad2_state;
            end else begin
                if (rd1)
                    shift1 <= shift_in_one(shift1);
                if (rd2)
                    shift2 <= shift_in_one(shift2);
            end
        end
    end

endmodule
